piece_fall_ctrl: RTL

PIECE_FALL_CTRL -- requirements
Module: piece_fall_ctrl

---
 rtl/tetris_pkg.sv | 10 +
 rtl/piece_fall_ctrl_if.sv | 33 +++
 rtl/grav_timer.sv | 17 +
 rtl/piece_fall_ctrl.sv | 126 ++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// tetris_pkg: shared FSM states, HID keycodes and board geometry
package tetris_pkg;
   typedef enum logic [2:0] {IDLE, SPAWN, FALL, LOCK, SCAN, CLEAR, GAMEOVER} state_t;
   localparam logic [7:0] KEY_LEFT  = 8'h04;
   localparam logic [7:0] KEY_RIGHT = 8'h07;
   localparam logic [7:0] KEY_ROT   = 8'h1A;
   localparam logic [7:0] KEY_DROP  = 8'h16;
   localparam int BOARD_ROWS = 22;
   localparam int BOARD_COLS = 12;
endpackage

// File: rtl/piece_fall_ctrl_if.sv
// piece_fall_ctrl_if: board and shape-datapath signals of the falling-piece controller
interface piece_fall_ctrl_if;
   import tetris_pkg::*;
   logic                  start;
   logic [7:0]            keycode;
   logic                  hit_down;
   logic                  hit_left;
   logic                  hit_right;
   logic                  hit_spawn;
   logic [BOARD_ROWS-1:0] row_full;
   logic                  clear_ack;
   logic                  firstgen;
   logic                  newgen;
   logic                  update;
   logic [4:0]            row_out;
   logic [3:0]            col_out;
   logic                  lock;
   logic                  clear_req;
   logic [4:0]            clear_row;
   logic [7:0]            lines;
   logic                  game_over;
   state_t                state;
   modport master (
      input  start, keycode, hit_down, hit_left, hit_right, hit_spawn, row_full, clear_ack,
      output firstgen, newgen, update, row_out, col_out, lock, clear_req, clear_row, lines,
             game_over, state
   );
   modport slave (
      output start, keycode, hit_down, hit_left, hit_right, hit_spawn, row_full, clear_ack,
      input  firstgen, newgen, update, row_out, col_out, lock, clear_req, clear_row, lines,
             game_over, state
   );
endinterface

// File: rtl/grav_timer.sv
// grav_timer: counts frames and flags the frame on which a gravity step is due
module grav_timer #(
   parameter int GRAV_FRAMES = 30
) (
   input  logic vsync,
   input  logic reset_n,
   input  logic enable,
   input  logic clear,
   output logic tick
);
   logic [5:0] cnt;
   assign tick = cnt == 6'(GRAV_FRAMES - 1);
   // wrap to 0 after the due frame; holding enable low parks the count on the due frame
   always_ff @(posedge vsync)
      if (!reset_n || clear) cnt <= '0;
      else if (enable) cnt <= tick ? '0 : cnt + 6'd1;
endmodule

// File: rtl/piece_fall_ctrl.sv
// piece_fall_ctrl: falling-piece FSM; define SOFT_DROP_EN so a held 0x16 forces a drop every frame
module piece_fall_ctrl
   import tetris_pkg::*;
#(
   parameter int GRAV_FRAMES = 30,
   parameter int SPAWN_COL   = 4
) (
   input logic               vsync,
   input logic               reset_n,
   piece_fall_ctrl_if.master bus
);
`ifdef SOFT_DROP_EN
   localparam bit SOFT_DROP = 1'b1;
`else
   localparam bit SOFT_DROP = 1'b0;
`endif
   localparam logic [4:0] LAST_ROW = 5'(BOARD_ROWS - 1);
   localparam logic [3:0] LAST_COL = 4'(BOARD_COLS - 1);
   localparam logic [3:0] HOME_COL = 4'(SPAWN_COL);
   state_t     state;
   logic [4:0] row, ptr;
   logic [3:0] col;
   logic [7:0] lines, prev_key;
   logic       firstgen, newgen, update, lock, clear_req, game_over, first;
   logic       in_fall, press, act_l, act_r, act_rot, act, drop, tick, step;
   assign in_fall = state == FALL;
   assign press   = bus.keycode != 8'h00 && bus.keycode != prev_key;
   assign act_l   = press && bus.keycode == KEY_LEFT;
   assign act_r   = press && bus.keycode == KEY_RIGHT;
   assign act_rot = press && bus.keycode == KEY_ROT;
   assign act     = act_l | act_r | act_rot;
   assign drop    = SOFT_DROP && in_fall && bus.keycode == KEY_DROP;
   assign step    = drop || (tick && !act);
   // a key action on the due frame parks the timer there so gravity lands one frame later
   grav_timer #(.GRAV_FRAMES(GRAV_FRAMES)) u_timer (
      .vsync   (vsync),
      .reset_n (reset_n),
      .enable  (!(tick && act)),
      .clear   (!in_fall || drop),
      .tick    (tick)
   );
   // game FSM with all outputs registered; strobes default low each frame
   always_ff @(posedge vsync)
      if (!reset_n) begin
         state     <= IDLE;
         row       <= '0;
         col       <= HOME_COL;
         ptr       <= LAST_ROW;
         lines     <= '0;
         prev_key  <= '0;
         firstgen  <= 1'b0;
         newgen    <= 1'b0;
         update    <= 1'b0;
         lock      <= 1'b0;
         clear_req <= 1'b0;
         game_over <= 1'b0;
         first     <= 1'b0;
      end else begin
         prev_key <= bus.keycode;
         firstgen <= 1'b0;
         newgen   <= 1'b0;
         update   <= 1'b0;
         lock     <= 1'b0;
         case (state)
            IDLE, GAMEOVER:
               if (bus.start) begin
                  state     <= SPAWN;
                  firstgen  <= 1'b1;
                  first     <= 1'b1;
                  lines     <= '0;
                  game_over <= 1'b0;
               end
            SPAWN: begin
               row   <= '0;
               col   <= HOME_COL;
               first <= 1'b0;
               if (bus.hit_spawn) begin
                  state     <= GAMEOVER;
                  game_over <= 1'b1;
               end else begin
                  state  <= FALL;
                  newgen <= !first;
               end
            end
            FALL: begin
               if (act_l && !bus.hit_left && col != 4'd0) col <= col - 4'd1;
               if (act_r && !bus.hit_right && col != LAST_COL) col <= col + 4'd1;
               update <= act_rot;
               if (step) begin
                  if (bus.hit_down || row == LAST_ROW) begin
                     state <= LOCK;
                     lock  <= 1'b1;
                  end else row <= row + 5'd1;
               end
            end
            LOCK: begin
               state <= SCAN;
               ptr   <= LAST_ROW;
            end
            SCAN:
               if (bus.row_full[ptr]) begin
                  state     <= CLEAR;
                  clear_req <= 1'b1;
               end else if (ptr == 5'd0) state <= SPAWN;
               else ptr <= ptr - 5'd1;
            CLEAR:
               if (bus.clear_ack) begin
                  state     <= SCAN;
                  clear_req <= 1'b0;
                  lines     <= lines + 8'(lines != 8'hFF);
               end
            default: state <= IDLE;
         endcase
      end
   assign bus.state     = state;
   assign bus.row_out   = row;
   assign bus.col_out   = col;
   assign bus.clear_row = ptr;
   assign bus.lines     = lines;
   assign bus.firstgen  = firstgen;
   assign bus.newgen    = newgen;
   assign bus.update    = update;
   assign bus.lock      = lock;
   assign bus.clear_req = clear_req;
   assign bus.game_over = game_over;
endmodule
